// File: rtl/alu_pkg.sv
// Shared definitions for the alu32 datapath and the round-robin scheduler
// that time-multiplexes it between several requesters.
//   - alu_op_t           : opcode encoding understood by alu32
//   - alu_sched_state_t  : scheduler FSM states
//   - alu_op_legal()     : true when a raw 4-bit opcode maps onto alu_op_t
package alu_pkg;

    localparam int ALU_W       = 32;
    localparam int ALU_NUM_OPS = 9;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_SLT = 4'd8
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_sched_state_t;

    // Opcodes are dense from zero, so legality is a single compare.
    function automatic bit alu_op_legal(input logic [3:0] op);
        return (op < 4'(ALU_NUM_OPS));
    endfunction

endpackage

// File: rtl/alu32.sv
// Purely combinational 32-bit ALU.
//   a, b : operands          op : alu_op_t opcode
//   y    : result            z/n/c/v : zero, negative, carry, overflow
// SUB sets c as "no borrow" (a >= b unsigned). c and v are 0 for
// non-arithmetic ops. Unknown opcodes produce y = 0.
module alu32
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  alu_op_t          op,
    output logic [ALU_W-1:0] y,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v
);

    logic [ALU_W:0] sum_s;
    logic [ALU_W:0] dif_s;

    // Result and flag generation for every opcode.
    always_comb begin
        sum_s = {1'b0, a} + {1'b0, b};
        dif_s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        y     = 32'd0;
        c     = 1'b0;
        v     = 1'b0;
        case (op)
            ALU_ADD: begin
                y = sum_s[ALU_W-1:0];
                c = sum_s[ALU_W];
                v = (a[31] == b[31]) && (sum_s[31] != a[31]);
            end
            ALU_SUB: begin
                y = dif_s[ALU_W-1:0];
                c = dif_s[ALU_W];
                v = (a[31] != b[31]) && (dif_s[31] != a[31]);
            end
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLL: y = a << b[4:0];
            ALU_SRL: y = a >> b[4:0];
            ALU_SRA: y = $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT: y = {31'd0, ($signed(a) < $signed(b))};
            default: y = 32'd0;
        endcase
        z = (y == 32'd0);
        n = y[31];
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Combinational round-robin arbiter. The search starts one past last_grant
// and wraps, so the most recently served requester has lowest priority.
//   req        : request bits          last_grant : previous winner
//   en         : allows a grant        gnt_onehot : one-hot grant (0 if !en)
//   gnt_idx    : index of the winner   any        : a grant is being issued
module alu_rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    input  logic          en,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic found_s;
    int   idx_s;

    // Rotating priority search; first hit after last_grant wins.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found_s    = 1'b0;
        idx_s      = 0;
        for (int k = 1; k <= N; k++) begin
            idx_s = (int'(last_grant) + k) % N;
            if (!found_s && req[idx_s[IW-1:0]]) begin
                found_s                 = 1'b1;
                gnt_idx                 = idx_s[IW-1:0];
                gnt_onehot[idx_s[IW-1:0]] = en;
            end else begin
                found_s = found_s;
            end
        end
        any = found_s && en;
    end

endmodule

// File: rtl/alu_rr_sched.sv
// Shares one alu32 between NUM_REQ requesters.
//   clk, rst_n                   : clock, async active-low reset
//   req_valid/req_ready          : per-requester handshake (ready one-hot or 0)
//   req_a, req_b, req_op         : packed operands/opcodes, slot i at i*width
//   resp_valid/resp_ready        : single response channel
//   resp_y, resp_z/n/c/v, resp_id, resp_err : registered result, flags, source
//   busy                         : scheduler not idle
//   done_cnt                     : completed responses, wrapping
// One operation is in flight at a time: IDLE accepts, EXEC captures the
// ALU output, RESP holds it until the consumer takes it.
module alu_rr_sched
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*ALU_W-1:0] req_a,
    input  logic [NUM_REQ*ALU_W-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]     req_op,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ALU_W-1:0]         resp_y,
    output logic                     resp_z,
    output logic                     resp_n,
    output logic                     resp_c,
    output logic                     resp_v,
    output logic [ID_W-1:0]          resp_id,
    output logic                     resp_err,
    output logic                     busy,
    output logic [CNT_W-1:0]         done_cnt
);

    alu_sched_state_t state_r;
    logic [ID_W-1:0]  last_grant_r;
    logic [ALU_W-1:0] a_r;
    logic [ALU_W-1:0] b_r;
    logic [3:0]       op_r;
    logic [ID_W-1:0]  id_r;

    logic [NUM_REQ-1:0] gnt_onehot_s;
    logic [ID_W-1:0]    gnt_idx_s;
    logic               any_s;
    logic               en_s;
    logic [ALU_W-1:0]   y_s;
    logic               z_s, n_s, c_s, v_s;

    // Grants only while idle; held off during reset so ready reads 0.
    assign en_s      = (state_r == IDLE) && rst_n;
    assign req_ready = gnt_onehot_s;
    assign busy      = (state_r != IDLE);

    alu_rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .en         (en_s),
        .gnt_onehot (gnt_onehot_s),
        .gnt_idx    (gnt_idx_s),
        .any        (any_s)
    );

    alu32 u_alu (
        .a  (a_r),
        .b  (b_r),
        .op (alu_op_t'(op_r)),
        .y  (y_s),
        .z  (z_s),
        .n  (n_s),
        .c  (c_s),
        .v  (v_s)
    );

    // Scheduler FSM with all operand and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= ID_W'(NUM_REQ - 1);
            a_r          <= '0;
            b_r          <= '0;
            op_r         <= 4'd0;
            id_r         <= '0;
            resp_valid   <= 1'b0;
            resp_y       <= '0;
            resp_z       <= 1'b0;
            resp_n       <= 1'b0;
            resp_c       <= 1'b0;
            resp_v       <= 1'b0;
            resp_id      <= '0;
            resp_err     <= 1'b0;
            done_cnt     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        a_r          <= req_a[int'(gnt_idx_s)*ALU_W +: ALU_W];
                        b_r          <= req_b[int'(gnt_idx_s)*ALU_W +: ALU_W];
                        op_r         <= req_op[int'(gnt_idx_s)*4 +: 4];
                        id_r         <= gnt_idx_s;
                        last_grant_r <= gnt_idx_s;
                        state_r      <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    // Illegal opcodes report an error with a zeroed result.
                    if (alu_op_legal(op_r)) begin
                        resp_y   <= y_s;
                        resp_z   <= z_s;
                        resp_n   <= n_s;
                        resp_c   <= c_s;
                        resp_v   <= v_s;
                        resp_err <= 1'b0;
                    end else begin
                        resp_y   <= '0;
                        resp_z   <= 1'b0;
                        resp_n   <= 1'b0;
                        resp_c   <= 1'b0;
                        resp_v   <= 1'b0;
                        resp_err <= 1'b1;
                    end
                    resp_id    <= id_r;
                    resp_valid <= 1'b1;
                    state_r    <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        done_cnt   <= done_cnt + CNT_W'(1);
                        state_r    <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Self-checking bench for alu_rr_sched (NUM_REQ = 2): directed vector table,
// contention / backpressure / reset sequences, and randomized operations
// compared against an arithmetic reference model.
module tb_alu_rr_sched;
    import alu_pkg::*;

    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*32-1:0] req_a;
    logic [NR*32-1:0] req_b;
    logic [NR*4-1:0] req_op;
    logic            resp_valid;
    logic            resp_ready;
    logic [31:0]     resp_y;
    logic            resp_z, resp_n, resp_c, resp_v;
    logic [0:0]      resp_id;
    logic            resp_err;
    logic            busy;
    logic [15:0]     done_cnt;

    int checks = 0;
    int errors = 0;
    int exp_done = 0;
    int got_id_q[$];
    logic [31:0] got_y_q[$];

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] y;
        logic [3:0]  zncv;
        logic        err;
    } vec_t;

    vec_t tbl[11];

    always #5 clk = ~clk;

    alu_rr_sched #(.NUM_REQ(NR), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_y(resp_y), .resp_z(resp_z), .resp_n(resp_n),
        .resp_c(resp_c), .resp_v(resp_v), .resp_id(resp_id),
        .resp_err(resp_err), .busy(busy), .done_cnt(done_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference ALU from the arithmetic definition: {err, z, n, c, v, y}.
    function automatic logic [36:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        longint sa, sb, ua, ub, r;
        logic [31:0] y;
        logic c, v, err, z, n;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        y = 32'd0; c = 1'b0; v = 1'b0; err = 1'b0; r = 64'sd0;
        case (op)
            4'd0: begin
                r = ua + ub; y = r[31:0]; c = (r > 64'sd4294967295);
                r = sa + sb; v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            4'd1: begin
                r = ua - ub; y = r[31:0]; c = (ua >= ub);
                r = sa - sb; v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            4'd2: y = a & b;
            4'd3: y = a | b;
            4'd4: y = a ^ b;
            4'd5: y = a << b[4:0];
            4'd6: y = a >> b[4:0];
            4'd7: begin r = sa >>> b[4:0]; y = r[31:0]; end
            4'd8: y = (sa < sb) ? 32'd1 : 32'd0;
            default: err = 1'b1;
        endcase
        z = !err && (y == 32'd0);
        n = !err && y[31];
        return {err, z, n, c, v, y};
    endfunction

    // Issue one operation from a single requester and check it end to end.
    task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [36:0] exp,
                         input int stall, input string tag);
        logic [1:0] onehot;
        onehot = 2'b01 << id;
        @(negedge clk);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_op[4*id +: 4]  = op;
        req_valid  = onehot;
        resp_ready = (stall == 0);
        #1;
        chk({tag, ".ready"}, 64'(req_ready), 64'(onehot));
        @(negedge clk);
        req_valid = '0;
        #1;
        chk({tag, ".exec_novalid"}, 64'(resp_valid), 64'd0);
        chk({tag, ".exec_busy"}, 64'(busy), 64'd1);
        @(negedge clk);
        #1;
        chk({tag, ".valid"}, 64'(resp_valid), 64'd1);
        chk({tag, ".y"}, 64'(resp_y), 64'(exp[31:0]));
        chk({tag, ".zncv"}, 64'({resp_z, resp_n, resp_c, resp_v}), 64'(exp[35:32]));
        chk({tag, ".err"}, 64'(resp_err), 64'(exp[36]));
        chk({tag, ".id"}, 64'(resp_id), 64'(id));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            #1;
            chk({tag, ".hold_valid"}, 64'(resp_valid), 64'd1);
            chk({tag, ".hold_y"}, 64'(resp_y), 64'(exp[31:0]));
        end
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        exp_done++;
        chk({tag, ".done_cnt"}, 64'(done_cnt), 64'(exp_done));
        chk({tag, ".after_valid"}, 64'(resp_valid), 64'd0);
    endtask

    // Requester 0 = 50 SUB 8, requester 1 = 0xF0F0 AND 0x0FF0; each drops
    // valid once accepted. Collects responses in arrival order.
    task automatic run_seq(input logic [1:0] start_mask, input logic [1:0] late_mask,
                           input int n_exp, input string tag);
        logic [1:0] acc;
        acc = '0;
        got_id_q.delete();
        got_y_q.delete();
        @(negedge clk);
        req_a[31:0] = 32'd50;     req_b[31:0] = 32'd8;      req_op[3:0] = 4'd1;
        req_a[63:32] = 32'hF0F0;  req_b[63:32] = 32'h0FF0;  req_op[7:4] = 4'd2;
        resp_ready = 1'b1;
        req_valid  = start_mask;
        for (int cyc = 0; cyc < 40 && got_id_q.size() < n_exp; cyc++) begin
            req_valid = req_valid & ~acc;
            if (cyc == 1) req_valid = req_valid | late_mask;
            #1;
            if (resp_valid) begin
                got_id_q.push_back(int'(resp_id));
                got_y_q.push_back(resp_y);
            end
            acc = req_ready;
            @(negedge clk);
        end
        req_valid = '0;
        chk({tag, ".count"}, 64'(got_id_q.size()), 64'(n_exp));
        exp_done += n_exp;
    endtask

    task automatic chk_order(input string tag, input int id0, input int id1);
        logic [31:0] ey0, ey1;
        ey0 = (id0 == 0) ? 32'd42 : 32'h00F0;
        ey1 = (id1 == 0) ? 32'd42 : 32'h00F0;
        if (got_id_q.size() >= 2) begin
            chk({tag, ".first_id"}, 64'(got_id_q[0]), 64'(id0));
            chk({tag, ".first_y"}, 64'(got_y_q[0]), 64'(ey0));
            chk({tag, ".second_id"}, 64'(got_id_q[1]), 64'(id1));
            chk({tag, ".second_y"}, 64'(got_y_q[1]), 64'(ey1));
        end else begin
            chk({tag, ".responses"}, 64'(got_id_q.size()), 64'd2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [3:0]  rop;
        int          rid;

        tbl[0]  = '{0, 32'd10,        32'd20,        4'd0,  32'd30,        4'b0000, 1'b0};
        tbl[1]  = '{1, 32'd1,         32'd1,         4'd12, 32'd0,         4'b0000, 1'b1};
        tbl[2]  = '{1, 32'd5,         32'd7,         4'd0,  32'd12,        4'b0000, 1'b0};
        tbl[3]  = '{0, 32'hFFFFFFFB,  32'd3,         4'd8,  32'd1,         4'b0000, 1'b0};
        tbl[4]  = '{0, 32'h7FFFFFFF,  32'd1,         4'd0,  32'h80000000,  4'b0101, 1'b0};
        tbl[5]  = '{1, 32'd50,        32'd8,         4'd1,  32'd42,        4'b0010, 1'b0};
        tbl[6]  = '{0, 32'hF0F0,      32'h0FF0,      4'd2,  32'h00F0,      4'b0000, 1'b0};
        tbl[7]  = '{1, 32'd5,         32'd5,         4'd1,  32'd0,         4'b1010, 1'b0};
        tbl[8]  = '{0, 32'hFFFFFFFF,  32'd1,         4'd0,  32'd0,         4'b1010, 1'b0};
        tbl[9]  = '{0, 32'h80000000,  32'd4,         4'd7,  32'hF8000000,  4'b0100, 1'b0};
        tbl[10] = '{1, 32'd3,         32'd3,         4'd9,  32'd0,         4'b0000, 1'b1};

        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; resp_ready = 1'b0;
        #12;
        chk("rst.resp_valid", 64'(resp_valid), 64'd0);
        chk("rst.done_cnt", 64'(done_cnt), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.req_ready", 64'(req_ready), 64'd0);
        chk("rst.resp_y", 64'(resp_y), 64'd0);
        chk("rst.resp_flags", 64'({resp_z, resp_n, resp_c, resp_v, resp_err, resp_id}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Contention straight out of reset: requester 0 must win first.
        run_seq(2'b11, 2'b00, 2, "cont1");
        chk_order("cont1", 0, 1);
        run_seq(2'b11, 2'b00, 2, "cont2");
        chk_order("cont2", 0, 1);
        run_seq(2'b10, 2'b01, 2, "cont3");
        chk_order("cont3", 1, 0);
        #1;
        chk("cont.done_cnt", 64'(done_cnt), 64'(exp_done));

        for (int i = 0; i < 11; i++) begin
            do_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].op,
                  {tbl[i].err, tbl[i].zncv, tbl[i].y}, 0, $sformatf("vec%0d", i));
        end

        // Backpressure: 100 SUB 200 held for five cycles while req1 waits.
        @(negedge clk);
        req_a[31:0] = 32'd100; req_b[31:0] = 32'd200; req_op[3:0] = 4'd1;
        req_valid = 2'b01; resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 2'b10;
        @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("bp.valid", 64'(resp_valid), 64'd1);
            chk("bp.y", 64'(resp_y), 64'hFFFFFF9C);
            chk("bp.id_flags", 64'({resp_id, resp_z, resp_n, resp_c, resp_v, resp_err}), 64'b0_0100_0);
            chk("bp.req_ready", 64'(req_ready), 64'd0);
            chk("bp.busy", 64'(busy), 64'd1);
            chk("bp.done_cnt", 64'(done_cnt), 64'(exp_done));
            @(negedge clk);
        end
        req_valid = '0;
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        exp_done++;
        chk("bp.done_after", 64'(done_cnt), 64'(exp_done));
        chk("bp.valid_after", 64'(resp_valid), 64'd0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 60; i++) begin
            rid = int'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            rop = ($urandom_range(0, 9) == 9) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            do_op(rid, ra, rb, rop, ref_alu(ra, rb, rop), int'($urandom_range(0, 2)),
                  $sformatf("rnd%0d", i));
        end

        // Reset during EXEC: nothing may survive, counter clears.
        @(negedge clk);
        req_a[31:0] = 32'd3; req_b[31:0] = 32'd4; req_op[3:0] = 4'd0;
        req_valid = 2'b01; resp_ready = 1'b1;
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("mid.exec_busy", 64'(busy), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid.resp_valid", 64'(resp_valid), 64'd0);
        chk("mid.done_cnt", 64'(done_cnt), 64'd0);
        chk("mid.busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_done = 0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            #1;
            chk("mid.no_stale", 64'(resp_valid), 64'd0);
        end
        run_seq(2'b11, 2'b00, 2, "post_rst");
        chk_order("post_rst", 0, 1);
        #1;
        chk("post_rst.done_cnt", 64'(done_cnt), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
